bcd_7seg_scan: RTL and testbench

- Display stage directly downstream of the 4-bit binary-to-2-digit BCD converter.
- Captures the packed 8-bit BCD value {tens, ones} on a load strobe.
- Time-multiplexes it onto a 4-digit common-anode 7-segment display: two active digits, two blank slots.
- Provides a prescaled scan, optional leading-zero blanking, a dash glyph for invalid digits, and an error flag.

---
 rtl/bcd_7seg_scan.sv | 137 +++++++++++++
 tb/tb_bcd_7seg_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: display stage for a packed two-digit BCD value.
// Captures {tens, ones} on a load strobe and time-multiplexes it onto a
// 4-digit common-anode 7-segment display. Slots 0/1 carry the ones and
// tens digits. Slots 2/3 stay dark so each active digit keeps a 1/4 duty.
// Invalid nibbles (A..F) show a dash and raise err.

module bcd_7seg_scan #(
    parameter int CLK_DIV = 100000   // clock cycles per digit slot, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       lz_blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       err
);

    localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_ONES  = 4'b1110;
    localparam logic [3:0] AN_TENS  = 4'b1101;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_D0,   // ones digit
        S_D1,   // tens digit
        S_D2,   // unused slot, dark
        S_D3    // unused slot, dark
    } state_t;

    state_t        state;
    logic [7:0]    bcd_reg;
    logic [CW-1:0] cnt;
    logic          tick;

    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          err_nxt;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal nibbles map to a dash.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_DASH;
        endcase
    endfunction

    assign tens = bcd_reg[7:4];
    assign ones = bcd_reg[3:0];
    assign tick = (cnt == CNT_MAX);
    assign dp   = 1'b1;

    // Capture register: load may be held high, in which case it re-captures every cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, regardless of block ordering.
        if (rst)
            bcd_reg <= 8'h00;
        else if (load)
            bcd_reg <= bcd_in;
    end

    // Prescaler: one tick every CLK_DIV cycles, wrapping to 0 on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Next anode/segment/err values from the current slot and stored digits.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        err_nxt = (tens > 4'd9) | (ones > 4'd9);
        case (state)
            S_D0: begin
                an_nxt  = AN_ONES;
                seg_nxt = glyph(ones);
            end
            S_D1: begin
                if (!(lz_blank && (tens == 4'd0))) begin
                    an_nxt  = AN_TENS;
                    seg_nxt = glyph(tens);
                end
            end
            default: begin
                an_nxt  = AN_OFF;
                seg_nxt = SEG_OFF;
            end
        endcase
    end

    // Scan FSM with registered outputs: slot advances on tick, outputs follow one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_D0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            err   <= 1'b0;
        end else begin
            if (tick) begin
                case (state)
                    S_D0:    state <= S_D1;
                    S_D1:    state <= S_D2;
                    S_D2:    state <= S_D3;
                    default: state <= S_D0;
                endcase
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// tb_bcd_7seg_scan: directed vectors with hand-computed glyphs. Stimulus
// pushes cycle-stamped expected frames into a queue; a monitor pops and
// compares them on the falling edge.

module tb_bcd_7seg_scan;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] bcd_in = 8'h00;
    logic       load = 1'b0;
    logic       lz_blank = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [6:0] seg;
        logic       err;
        string      nm;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic [7:0] val;
        logic       lz;
        logic [6:0] seg0;
        logic [3:0] an1;
        logic [6:0] seg1;
        logic       err;
        string      nm;
    } vec_t;

    bcd_7seg_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .load     (load),
        .lz_blank (lz_blank),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; output at cycle k reflects the slot ((k-1)/4)%4.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, req);
        end
    endtask

    // Monitor: pop every expectation stamped for the current cycle.
    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].t <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.t < cyc) begin
                    check($sformatf("%s missed@%0d", e.nm, e.t), 16'(cyc), 16'(e.t));
                end else begin
                    check($sformatf("%s an@%0d", e.nm, cyc), 16'(an), 16'(e.an));
                    check($sformatf("%s seg@%0d", e.nm, cyc), 16'(seg), 16'(e.seg));
                    check($sformatf("%s err@%0d", e.nm, cyc), 16'(err), 16'(e.err));
                    check($sformatf("%s dp@%0d", e.nm, cyc), 16'(dp), 16'(1'b1));
                end
            end
        end
    end

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push n per-cycle expectations from cycle base: slot 0 = ones, 1 = tens, 2/3 dark.
    task automatic push_period(input int base, input int n, input logic [6:0] seg0,
                               input logic [3:0] an1, input logic [6:0] seg1,
                               input logic e_err, input string nm);
        for (int j = 0; j < n; j++) begin
            exp_t e;
            int   slot;
            e.t   = base + j;
            slot  = ((e.t - 1) / CLK_DIV) % 4;
            e.err = e_err;
            e.nm  = nm;
            case (slot)
                0:       begin e.an = 4'b1110; e.seg = seg0;       end
                1:       begin e.an = an1;     e.seg = seg1;       end
                default: begin e.an = 4'b1111; e.seg = 7'b1111111; end
            endcase
            q.push_back(e);
        end
    endtask

    // Single-cycle load strobe; returns one edge after the capture edge minus the settle delay.
    task automatic do_load(input logic [7:0] v);
        bcd_in = v;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load   = 1'b0;
    endtask

    task automatic check_dark(input string nm);
        check({nm, " an"}, 16'(an), 16'(4'b1111));
        check({nm, " seg"}, 16'(seg), 16'(7'b1111111));
        check({nm, " dp"}, 16'(dp), 16'(1'b1));
        check({nm, " err"}, 16'(err), 16'(1'b0));
    endtask

    vec_t vecs[8];

    initial begin
        int start;
        int bound;

        vecs[0] = '{8'h15, 1'b0, 7'b0010010, 4'b1101, 7'b1111001, 1'b0, "v15"};
        vecs[1] = '{8'h07, 1'b1, 7'b1111000, 4'b1111, 7'b1111111, 1'b0, "v07_lz1"};
        vecs[2] = '{8'h07, 1'b0, 7'b1111000, 4'b1101, 7'b1000000, 1'b0, "v07_lz0"};
        vecs[3] = '{8'h1A, 1'b0, 7'b0111111, 4'b1101, 7'b1111001, 1'b1, "v1A"};
        vecs[4] = '{8'h09, 1'b0, 7'b0010000, 4'b1101, 7'b1000000, 1'b0, "v09"};
        vecs[5] = '{8'h38, 1'b0, 7'b0000000, 4'b1101, 7'b0110000, 1'b0, "v38"};
        vecs[6] = '{8'h6B, 1'b1, 7'b0111111, 4'b1101, 7'b0000010, 1'b1, "v6B"};
        vecs[7] = '{8'hF2, 1'b0, 7'b0100100, 4'b1101, 7'b0111111, 1'b1, "vF2"};

        // Asynchronous reset assertion between clock edges.
        #2 rst = 1'b1;
        #1 check_dark("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        push_period(1, 16, 7'b1000000, 4'b1101, 7'b1000000, 1'b0, "post_rst");
        wait_cyc(17);

        // Directed vectors: load, then check one full 16-cycle refresh.
        for (int i = 0; i < 8; i++) begin
            lz_blank = vecs[i].lz;
            do_load(vecs[i].val);
            start = cyc + 1;
            push_period(start, 16, vecs[i].seg0, vecs[i].an1, vecs[i].seg1,
                        vecs[i].err, vecs[i].nm);
            wait_cyc(start + 16);
        end

        // Load coincident with the tick edge leaving S_D0.
        lz_blank = 1'b0;
        while (((cyc + 1) % (4 * CLK_DIV)) != CLK_DIV) begin
            @(posedge clk);
            #1;
        end
        do_load(8'h42);
        start = cyc + 1;
        push_period(start, 16, 7'b0100100, 4'b1101, 7'b0011001, 1'b0, "tick_load42");
        wait_cyc(start + 16);

        // Mid-scan reset while the tens slot is lit.
        do_load(8'h99);
        wait_cyc(cyc + 2);
        while ((((cyc - 1) / CLK_DIV) % 4) != 1) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst an", 16'(an), 16'(4'b1101));
        check("pre_rst seg", 16'(seg), 16'(7'b0010000));
        #2 rst = 1'b1;
        #1 check_dark("rst_mid");
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        push_period(1, 16, 7'b1000000, 4'b1101, 7'b1000000, 1'b0, "resume");
        wait_cyc(17);

        // Drain the scoreboard with a bounded wait.
        bound = 0;
        while (q.size() > 0 && bound < 200) begin
            @(posedge clk);
            bound++;
        end
        check("queue_drained", 16'(q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
